// File: rtl/npi_rd_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : npi_rd_arb_if
// Brief    : Requester and NPI read-request/return signals of npi_rd_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface npi_rd_arb_if #(
  parameter int C_NUM_REQ = 3,
  parameter int C_AW      = 36,
  parameter int C_LW      = 14
) ();
  logic [C_NUM_REQ-1:0]      rq_req;
  logic [C_NUM_REQ*C_AW-1:0] rq_addr;
  logic [C_NUM_REQ*C_LW-1:0] rq_len;
  logic [C_NUM_REQ-1:0]      rq_ack;
  logic [C_NUM_REQ-1:0]      rq_gnt;
  logic [C_NUM_REQ-1:0]      rq_valid;
  logic [C_NUM_REQ-1:0]      rq_last;
  logic                      npi_req;
  logic [C_AW-1:0]           npi_addr;
  logic [C_LW-1:0]           npi_len;
  logic                      npi_ack;
  logic                      npi_valid;
  logic                      npi_last;

  // Arbiter side
  modport slave (
    input  rq_req, rq_addr, rq_len, npi_ack, npi_valid, npi_last,
    output rq_ack, rq_gnt, rq_valid, rq_last, npi_req, npi_addr, npi_len
  );

  // Requesters plus NPI side
  modport master (
    output rq_req, rq_addr, rq_len, npi_ack, npi_valid, npi_last,
    input  rq_ack, rq_gnt, rq_valid, rq_last, npi_req, npi_addr, npi_len
  );
endinterface
`default_nettype wire

// File: rtl/npi_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : npi_rd_arb
// Brief    : Round-robin arbiter sharing one NPI read port between requesters.
//            Optional macro NPI_ARB_STRICT0_EN gives requester 0 fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module npi_rd_arb #(
  parameter int C_NUM_REQ = 3,
  parameter int C_AW      = 36,
  parameter int C_LW      = 14
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  npi_rd_arb_if.slave bus,
  output logic [31:0] arb2dbg
);
  localparam int C_IW = (C_NUM_REQ > 1) ? $clog2(C_NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [C_IW-1:0]      r_ptr, w_ptr_nxt;
  logic [C_IW-1:0]      r_gidx, w_gidx_nxt;
  logic [C_NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [C_NUM_REQ-1:0] r_ack, w_ack_nxt;
  logic [C_NUM_REQ-1:0] r_vld, w_vld_nxt;
  logic [C_NUM_REQ-1:0] r_lst, w_lst_nxt;
  logic                 r_npi_req, w_npi_req_nxt;
  logic [C_AW-1:0]      r_addr, w_addr_nxt;
  logic [C_LW-1:0]      r_len, w_len_nxt;
  logic                 r_err, w_err_nxt;

  logic [C_NUM_REQ-1:0] w_req;
  logic                 w_hi_found, w_lo_found, w_found;
  logic [C_IW-1:0]      w_hi_sel, w_lo_sel, w_sel;

  // Winner search: first requester above the pointer, else first at/below it.
  always_comb begin
    w_req      = bus.rq_req;
`ifdef NPI_ARB_STRICT0_EN
    w_req[0]   = 1'b0;
`endif
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_sel   = '0;
    w_lo_sel   = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (w_req[i] && !w_hi_found && (i > int'(r_ptr))) begin
        w_hi_found = 1'b1;
        w_hi_sel   = C_IW'(i);
      end
      if (w_req[i] && !w_lo_found && (i <= int'(r_ptr))) begin
        w_lo_found = 1'b1;
        w_lo_sel   = C_IW'(i);
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_sel   = w_hi_found ? w_hi_sel : w_lo_sel;
`ifdef NPI_ARB_STRICT0_EN
    if (bus.rq_req[0]) begin
      w_found = 1'b1;
      w_sel   = '0;
    end
`endif
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gidx_nxt    = r_gidx;
    w_gnt_nxt     = r_gnt;
    w_addr_nxt    = r_addr;
    w_len_nxt     = r_len;
    w_ack_nxt     = '0;
    w_vld_nxt     = '0;
    w_lst_nxt     = '0;
    w_npi_req_nxt = 1'b0;
    w_err_nxt     = r_err;

    // Any beat outside S_DATA has no owner, including one riding on npi_ack.
    if (bus.npi_valid && (r_state != S_DATA))
      w_err_nxt = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_REQ;
          w_gidx_nxt  = w_sel;
          for (int i = 0; i < C_NUM_REQ; i++) begin
            w_gnt_nxt[i] = (w_sel == C_IW'(i));
            if (w_sel == C_IW'(i)) begin
              w_addr_nxt = bus.rq_addr[i*C_AW +: C_AW];
              w_len_nxt  = bus.rq_len[i*C_LW +: C_LW];
            end
          end
        end
      end
      S_REQ: begin
        if (bus.npi_ack) begin
          w_state_nxt = S_DATA;
          w_ack_nxt   = r_gnt;
        end else begin
          w_npi_req_nxt = 1'b1;
        end
      end
      S_DATA: begin
        w_vld_nxt = r_gnt & {C_NUM_REQ{bus.npi_valid}};
        w_lst_nxt = r_gnt & {C_NUM_REQ{bus.npi_valid & bus.npi_last}};
        if (bus.npi_valid && bus.npi_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
`ifdef NPI_ARB_STRICT0_EN
        if (r_gidx != '0)
          w_ptr_nxt = r_gidx;
`else
        w_ptr_nxt = r_gidx;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= C_IW'(C_NUM_REQ - 1);
      r_gidx    <= '0;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_vld     <= '0;
      r_lst     <= '0;
      r_npi_req <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gidx    <= w_gidx_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ack     <= w_ack_nxt;
      r_vld     <= w_vld_nxt;
      r_lst     <= w_lst_nxt;
      r_npi_req <= w_npi_req_nxt;
      r_addr    <= w_addr_nxt;
      r_len     <= w_len_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign bus.rq_ack   = r_ack;
  assign bus.rq_gnt   = r_gnt;
  assign bus.rq_valid = r_vld;
  assign bus.rq_last  = r_lst;
  assign bus.npi_req  = r_npi_req;
  assign bus.npi_addr = r_addr;
  assign bus.npi_len  = r_len;

  always_comb begin
    arb2dbg              = '0;
    arb2dbg[1:0]         = r_state;
    arb2dbg[8 +: C_IW]   = r_gidx;
    arb2dbg[16]          = r_err;
  end
endmodule
`default_nettype wire

// File: tb/tb_npi_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_npi_rd_arb
// Brief    : Scoreboard bench for npi_rd_arb (grants and steered beats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_npi_rd_arb;
  localparam int N  = 3;
  localparam int AW = 36;
  localparam int LW = 14;

  typedef struct {
    int idx;
  } grant_t;
  typedef struct {
    int idx;
    bit last;
  } beat_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] arb2dbg;

  npi_rd_arb_if #(.C_NUM_REQ(N), .C_AW(AW), .C_LW(LW)) bus ();

  npi_rd_arb #(.C_NUM_REQ(N), .C_AW(AW), .C_LW(LW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus),
    .arb2dbg  (arb2dbg)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int passed = 0;
  grant_t gq[$];
  beat_t  bq[$];
  logic [AW-1:0] exp_addr [N];
  logic [LW-1:0] exp_len  [N];

  grant_t        mon_g;
  beat_t         mon_b;
  logic [N-1:0]  mon_v;

  // Scoreboard: each rq_ack pulse consumes one expected grant, each steered beat one expected beat.
  always @(negedge sys_clk) begin
    if (bus.rq_ack !== '0) begin
      checks++;
      if (gq.size() == 0) begin
        $display("FAIL unexpected_ack rq_ack=%b required 000", bus.rq_ack);
      end else begin
        passed++;
        mon_g = gq.pop_front();
        mon_v = N'(1 << mon_g.idx);
        checks++;
        if (bus.rq_ack !== mon_v) $display("FAIL ack_onehot rq_ack=%b required %b", bus.rq_ack, mon_v);
        else passed++;
        checks++;
        if (bus.rq_gnt !== mon_v) $display("FAIL gnt_at_ack rq_gnt=%b required %b", bus.rq_gnt, mon_v);
        else passed++;
        checks++;
        if (bus.npi_addr !== exp_addr[mon_g.idx])
          $display("FAIL npi_addr npi_addr=%h required %h", bus.npi_addr, exp_addr[mon_g.idx]);
        else passed++;
        checks++;
        if (bus.npi_len !== exp_len[mon_g.idx])
          $display("FAIL npi_len npi_len=%0d required %0d", bus.npi_len, exp_len[mon_g.idx]);
        else passed++;
      end
    end
    if (bus.rq_valid !== '0 || bus.rq_last !== '0) begin
      checks++;
      if (bq.size() == 0) begin
        $display("FAIL unexpected_beat rq_valid=%b rq_last=%b required 000", bus.rq_valid, bus.rq_last);
      end else begin
        passed++;
        mon_b = bq.pop_front();
        mon_v = N'(1 << mon_b.idx);
        checks++;
        if (bus.rq_valid !== mon_v) $display("FAIL beat_valid rq_valid=%b required %b", bus.rq_valid, mon_v);
        else passed++;
        checks++;
        if (bus.rq_last !== (mon_b.last ? mon_v : 3'b000))
          $display("FAIL beat_last rq_last=%b required %b", bus.rq_last, mon_b.last ? mon_v : 3'b000);
        else passed++;
      end
    end
  end

  task automatic push_grant(input int idx);
    gq.push_back('{idx: idx});
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  // NPI responder: waits for npi_req, accepts it, returns the given number of beats.
  task automatic serve(input int idx, input int beats, input bit drop_req, input bit ack_last,
                       output int waited);
    waited = 0;
    do begin
      @(negedge sys_clk);
      waited++;
    end while (bus.npi_req !== 1'b1 && waited < 20);
    checks++;
    if (bus.npi_req !== 1'b1) begin
      $display("FAIL npi_req_timeout npi_req=%b required 1 within 20 cycles", bus.npi_req);
      return;
    end
    passed++;
    if (drop_req) bus.rq_req = '0;
    bus.npi_ack = 1'b1;
    if (ack_last) begin
      bus.npi_valid = 1'b1;
      bus.npi_last  = 1'b1;
    end
    @(posedge sys_clk); #1;
    bus.npi_ack   = 1'b0;
    bus.npi_valid = 1'b0;
    bus.npi_last  = 1'b0;
    for (int i = 0; i < beats; i++) begin
      bus.npi_valid = 1'b1;
      bus.npi_last  = (i == beats - 1);
      bq.push_back('{idx: idx, last: (i == beats - 1)});
      @(posedge sys_clk); #1;
    end
    bus.npi_valid = 1'b0;
    bus.npi_last  = 1'b0;
  endtask

  task automatic test_reset();
    wait_cycles(3);
    checks++;
    if ({bus.rq_ack, bus.rq_gnt, bus.rq_valid, bus.rq_last, bus.npi_req} !== '0)
      $display("FAIL reset_strobes ack/gnt/valid/last/req=%b required 0",
               {bus.rq_ack, bus.rq_gnt, bus.rq_valid, bus.rq_last, bus.npi_req});
    else passed++;
    checks++;
    if ({bus.npi_addr, bus.npi_len} !== '0)
      $display("FAIL reset_addr_len addr=%h len=%0d required 0", bus.npi_addr, bus.npi_len);
    else passed++;
    checks++;
    if (arb2dbg !== 32'h0) $display("FAIL reset_dbg arb2dbg=%h required 0", arb2dbg);
    else passed++;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_single();
    int w;
    @(posedge sys_clk); #1;
    bus.rq_req = 3'b100;
    push_grant(2);
    serve(2, 8, 1'b0, 1'b0, w);
    bus.rq_req = '0;
    checks++;
    if (w !== 3) $display("FAIL single_latency cycles=%0d required 3", w);
    else passed++;
    wait_cycles(3);
    checks++;
    if (bus.rq_gnt !== 3'b000 || arb2dbg[1:0] !== 2'd0)
      $display("FAIL single_release rq_gnt=%b state=%0d required 000/0", bus.rq_gnt, arb2dbg[1:0]);
    else passed++;
  endtask

  task automatic test_round_robin();
    int w;
    int order [6];
`ifdef NPI_ARB_STRICT0_EN
    order = '{0, 0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 0, 1, 2};
`endif
    @(posedge sys_clk); #1;
    bus.rq_req = 3'b111;
    for (int k = 0; k < 6; k++) push_grant(order[k]);
    for (int k = 0; k < 6; k++) begin
      serve(order[k], 1, 1'b0, 1'b0, w);
      if (k == 5) bus.rq_req = '0;
      checks++;
      if (w !== ((k == 0) ? 3 : 4))
        $display("FAIL rr_gap transfer=%0d cycles=%0d required %0d", k, w, (k == 0) ? 3 : 4);
      else passed++;
    end
    wait_cycles(4);
  endtask

  task automatic test_drop_req();
    int w;
    @(posedge sys_clk); #1;
    bus.rq_req = 3'b010;
    push_grant(1);
    serve(1, 2, 1'b1, 1'b0, w);
    wait_cycles(4);
    checks++;
    if (bus.rq_gnt !== 3'b000 || bus.npi_req !== 1'b0)
      $display("FAIL drop_no_regrant rq_gnt=%b npi_req=%b required 000/0", bus.rq_gnt, bus.npi_req);
    else passed++;
  endtask

  task automatic test_stray_idle();
    checks++;
    if (arb2dbg[16] !== 1'b0) $display("FAIL stray_pre err=%b required 0", arb2dbg[16]);
    else passed++;
    @(posedge sys_clk); #1;
    bus.npi_valid = 1'b1;
    bus.npi_last  = 1'b1;
    @(posedge sys_clk); #1;
    bus.npi_valid = 1'b0;
    bus.npi_last  = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (bus.rq_valid !== 3'b000 || arb2dbg[16] !== 1'b1)
      $display("FAIL stray_idle rq_valid=%b err=%b required 000/1", bus.rq_valid, arb2dbg[16]);
    else passed++;
    wait_cycles(5);
    checks++;
    if (arb2dbg[16] !== 1'b1) $display("FAIL stray_sticky err=%b required 1", arb2dbg[16]);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int w;
    @(posedge sys_clk); #1;
    bus.rq_req = 3'b100;
    push_grant(2);
    w = 0;
    do begin
      @(negedge sys_clk);
      w++;
    end while (bus.npi_req !== 1'b1 && w < 20);
    checks++;
    if (bus.npi_req !== 1'b1) $display("FAIL mid_req_timeout npi_req=%b required 1", bus.npi_req);
    else passed++;
    bus.npi_ack = 1'b1;
    @(posedge sys_clk); #1;
    bus.npi_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.npi_valid = 1'b1;
      bq.push_back('{idx: 2, last: 1'b0});
      @(posedge sys_clk); #1;
    end
    bus.npi_valid = 1'b0;
    bus.rq_req    = '0;
    sys_rst_n     = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    checks++;
    if ({bus.rq_ack, bus.rq_gnt, bus.rq_valid, bus.rq_last, bus.npi_req, bus.npi_addr, bus.npi_len} !== '0
        || arb2dbg !== 32'h0)
      $display("FAIL mid_reset_outputs ack=%b gnt=%b valid=%b last=%b req=%b addr=%h len=%0d dbg=%h required all 0",
               bus.rq_ack, bus.rq_gnt, bus.rq_valid, bus.rq_last, bus.npi_req, bus.npi_addr, bus.npi_len, arb2dbg);
    else passed++;
    @(posedge sys_clk); #1;
    sys_rst_n  = 1'b1;
    bus.rq_req = 3'b011;
    push_grant(0);
    serve(0, 1, 1'b0, 1'b0, w);
    bus.rq_req = '0;
    checks++;
    if (w !== 3) $display("FAIL post_reset_latency cycles=%0d required 3", w);
    else passed++;
    wait_cycles(4);
  endtask

  task automatic test_ack_last();
    int w;
    checks++;
    if (arb2dbg[16] !== 1'b0) $display("FAIL ack_last_pre err=%b required 0", arb2dbg[16]);
    else passed++;
    @(posedge sys_clk); #1;
    bus.rq_req = 3'b100;
    push_grant(2);
    serve(2, 1, 1'b0, 1'b1, w);
    bus.rq_req = '0;
    wait_cycles(3);
    checks++;
    if (arb2dbg[16] !== 1'b1 || bus.rq_gnt !== 3'b000)
      $display("FAIL ack_last_stray err=%b rq_gnt=%b required 1/000", arb2dbg[16], bus.rq_gnt);
    else passed++;
  endtask

  task automatic test_two_req();
    int w;
    int order [4] = '{1, 2, 1, 2};
    @(posedge sys_clk); #1;
    bus.rq_req = 3'b110;
    for (int k = 0; k < 4; k++) push_grant(order[k]);
    for (int k = 0; k < 4; k++) begin
      serve(order[k], 2, 1'b0, 1'b0, w);
      if (k == 3) bus.rq_req = '0;
    end
    wait_cycles(5);
  endtask

  initial begin
    bus.rq_req    = '0;
    bus.npi_ack   = 1'b0;
    bus.npi_valid = 1'b0;
    bus.npi_last  = 1'b0;
    exp_addr[0] = 36'h0_2000_0000;  exp_len[0] = 14'd64;
    exp_addr[1] = 36'h0_3000_0040;  exp_len[1] = 14'd128;
    exp_addr[2] = 36'h0_1000_0000;  exp_len[2] = 14'd512;
    for (int i = 0; i < N; i++) begin
      bus.rq_addr[i*AW +: AW] = exp_addr[i];
      bus.rq_len[i*LW +: LW]  = exp_len[i];
    end

    test_reset();
    test_single();
    test_round_robin();
    test_drop_req();
    test_stray_idle();
    test_mid_reset();
    test_ack_last();
    test_two_req();

    checks++;
    if (gq.size() != 0 || bq.size() != 0)
      $display("FAIL scoreboard_drain grants_left=%0d beats_left=%0d required 0/0", gq.size(), bq.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1);
  end
endmodule
`default_nettype wire
